// File: rtl/piece_queue.sv
// piece_queue
//   Turns the raw 3-bit LFSR value into legal tetromino codes 1..7, buffers
//   them in a small circular preview FIFO, and serves them to the game FSM
//   over a request/valid handshake together with a fixed RGB444 colour.
//
// Handshake: spawn_req is a one-cycle request pulse. If the queue holds a
//   piece, the head is popped on that edge and spawn_valid is high for exactly
//   the following cycle, with spawn_piece/spawn_colour valid in that cycle.
//   If the queue is empty, the request is parked (req_pending=1) and served
//   on the first cycle the queue becomes non-empty. Requests arriving while
//   parked, or during the cycle spawn_valid is high, are dropped (no queueing).
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high
//   rnd_in       raw random value, sampled every cycle
//   spawn_req    request pulse from the game FSM
//   spawn_valid  one-cycle pulse, spawn_piece/spawn_colour valid
//   spawn_piece  served piece code 1..7 (held after the pulse)
//   spawn_colour RGB444 colour of spawn_piece (held after the pulse)
//   next_piece   head of queue, 0 when empty
//   next_valid   queue non-empty
//   count        pieces held, 0..DEPTH
//   req_pending  a request is waiting for the queue to fill
//   dbg_state    serve FSM state (0 IDLE, 1 WAIT)
module piece_queue #(
  parameter int DEPTH     = 3,
  parameter int NO_REPEAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  rnd_in,
  input  logic        spawn_req,
  output logic        spawn_valid,
  output logic [2:0]  spawn_piece,
  output logic [11:0] spawn_colour,
  output logic [2:0]  next_piece,
  output logic        next_valid,
  output logic [2:0]  count,
  output logic        req_pending,
  output logic        dbg_state
);

  localparam int PW = (DEPTH <= 2) ? 1 : 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [2:0]      r_q [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [2:0]      r_count;
  logic [2:0]      r_last;
  logic            r_reroll_used;
  logic            r_spawn_valid;
  logic [2:0]      r_spawn_piece;
  logic [11:0]     r_spawn_colour;

  logic            w_nonempty;
  logic            w_pop;
  logic            w_slot;
  logic            w_is_zero;
  logic            w_is_repeat;
  logic            w_push;
  logic            w_reroll;
  logic [2:0]      w_head_piece;
  logic [11:0]     w_head_colour;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return PW'(p + 1'b1);
  endfunction

  assign w_nonempty   = (r_count != 3'd0);
  assign w_head_piece = r_q[r_head];

  // Serve FSM: next state and pop decision.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A request overlapping the spawn_valid cycle is dropped.
        if (spawn_req && !r_spawn_valid) begin
          if (w_nonempty) w_pop = 1'b1;
          else            w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_nonempty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Candidate acceptance. A full queue only takes a candidate when the head
  // leaves on the same edge. A rejected repeat spends the single reroll, so
  // at most one back-to-back duplicate is ever filtered.
  assign w_slot      = (r_count < 3'(DEPTH)) || w_pop;
  assign w_is_zero   = (rnd_in == 3'd0);
  assign w_is_repeat = (NO_REPEAT != 0) && (rnd_in == r_last) && !r_reroll_used;
  assign w_push      = w_slot && !w_is_zero && !w_is_repeat;
  assign w_reroll    = w_slot && !w_is_zero && w_is_repeat;

  always_comb begin
    w_head_colour = 12'h000;
    case (w_head_piece)
      3'd1:    w_head_colour = 12'h0FF;
      3'd2:    w_head_colour = 12'hFF0;
      3'd3:    w_head_colour = 12'hA0F;
      3'd4:    w_head_colour = 12'h0F0;
      3'd5:    w_head_colour = 12'hF00;
      3'd6:    w_head_colour = 12'h00F;
      3'd7:    w_head_colour = 12'hF80;
      default: w_head_colour = 12'h000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_q[i] <= 3'd0;
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= 3'd0;
      r_last         <= 3'd0;
      r_reroll_used  <= 1'b0;
      r_spawn_valid  <= 1'b0;
      r_spawn_piece  <= 3'd0;
      r_spawn_colour <= 12'h000;
    end else begin
      r_spawn_valid <= w_pop;
      if (w_pop) begin
        r_spawn_piece  <= w_head_piece;
        r_spawn_colour <= w_head_colour;
        r_head         <= ptr_inc(r_head);
      end
      if (w_push) begin
        r_q[r_tail]   <= rnd_in;
        r_tail        <= ptr_inc(r_tail);
        r_last        <= rnd_in;
        r_reroll_used <= 1'b0;
      end else if (w_reroll) begin
        r_reroll_used <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign spawn_valid  = r_spawn_valid;
  assign spawn_piece  = r_spawn_piece;
  assign spawn_colour = r_spawn_colour;
  assign next_piece   = w_nonempty ? w_head_piece : 3'd0;
  assign next_valid   = w_nonempty;
  assign count        = r_count;
  assign req_pending  = (r_state == ST_WAIT);
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_piece_queue.sv
// tb_piece_queue
//   Directed bench for piece_queue (DEPTH=3, NO_REPEAT=1). Inputs are driven
//   1 time unit after each rising edge and outputs are observed at the same
//   point, so each tick() shows the state produced by the edge just passed.
module tb_piece_queue;

  logic        clk;
  logic        reset;
  logic [2:0]  rnd_in;
  logic        spawn_req;
  logic        spawn_valid;
  logic [2:0]  spawn_piece;
  logic [11:0] spawn_colour;
  logic [2:0]  next_piece;
  logic        next_valid;
  logic [2:0]  count;
  logic        req_pending;
  logic        dbg_state;

  int checks;
  int errors;

  piece_queue #(.DEPTH(3), .NO_REPEAT(1)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .rnd_in       (rnd_in),
    .spawn_req    (spawn_req),
    .spawn_valid  (spawn_valid),
    .spawn_piece  (spawn_piece),
    .spawn_colour (spawn_colour),
    .next_piece   (next_piece),
    .next_valid   (next_valid),
    .count        (count),
    .req_pending  (req_pending),
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    rnd_in    = 3'd0;
    spawn_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Drives 0,3,3,5,2 from reset leaving the queue {3,5,2}.
  task automatic fill_352();
    logic [2:0] seq [5];
    seq = '{3'd0, 3'd3, 3'd3, 3'd5, 3'd2};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      rnd_in = seq[i];
      tick();
    end
    rnd_in = 3'd0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    rnd_in    = 3'd5;
    spawn_req = 1'b1;
    tick();
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (spawn_valid !== 1'b0) begin errors++; $display("FAIL reset_spawn_valid: got %0b expected 0", spawn_valid); end
    checks++; if (spawn_piece !== 3'd0) begin errors++; $display("FAIL reset_spawn_piece: got %0d expected 0", spawn_piece); end
    checks++; if (spawn_colour !== 12'h000) begin errors++; $display("FAIL reset_colour: got %03h expected 000", spawn_colour); end
    checks++; if (next_piece !== 3'd0 || next_valid !== 1'b0) begin errors++; $display("FAIL reset_next: got %0d/%0b expected 0/0", next_piece, next_valid); end
    checks++; if (req_pending !== 1'b0 || dbg_state !== 1'b0) begin errors++; $display("FAIL reset_fsm: got %0b/%0b expected 0/0", req_pending, dbg_state); end
    reset     = 1'b0;
    rnd_in    = 3'd0;
    spawn_req = 1'b0;
  endtask

  task automatic test_fill();
    fill_352();
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL fill_count: got %0d expected 3", count); end
    checks++; if (next_piece !== 3'd3 || next_valid !== 1'b1) begin errors++; $display("FAIL fill_next: got %0d/%0b expected 3/1", next_piece, next_valid); end
    rnd_in = 3'd1;
    tick();
    tick();
    rnd_in = 3'd0;
    checks++; if (count !== 3'd3 || next_piece !== 3'd3) begin errors++; $display("FAIL fill_full_ignore: got count %0d next %0d expected 3/3", count, next_piece); end
  endtask

  task automatic test_reroll();
    do_reset();
    rnd_in = 3'd4;
    tick();
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL reroll_first: got %0d expected 1", count); end
    tick();
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL reroll_reject: got %0d expected 1", count); end
    tick();
    rnd_in = 3'd0;
    checks++; if (count !== 3'd2 || next_piece !== 3'd4) begin errors++; $display("FAIL reroll_exhaust: got count %0d next %0d expected 2/4", count, next_piece); end
    // Drain to confirm the second entry is also 4.
    spawn_req = 1'b1; tick(); spawn_req = 1'b0; tick();
    spawn_req = 1'b1; tick(); spawn_req = 1'b0;
    checks++; if (spawn_piece !== 3'd4 || spawn_colour !== 12'h0F0 || count !== 3'd0) begin errors++; $display("FAIL reroll_second: got %0d %03h count %0d expected 4 0F0 0", spawn_piece, spawn_colour, count); end
    tick();
  endtask

  task automatic test_pop_latency();
    fill_352();
    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    checks++; if (spawn_valid !== 1'b1) begin errors++; $display("FAIL pop_valid: got %0b expected 1", spawn_valid); end
    checks++; if (spawn_piece !== 3'd3 || spawn_colour !== 12'hA0F) begin errors++; $display("FAIL pop_piece: got %0d %03h expected 3 A0F", spawn_piece, spawn_colour); end
    checks++; if (next_piece !== 3'd5 || count !== 3'd2) begin errors++; $display("FAIL pop_next: got %0d count %0d expected 5/2", next_piece, count); end
    tick();
    checks++; if (spawn_valid !== 1'b0 || spawn_piece !== 3'd3) begin errors++; $display("FAIL pop_hold: got %0b %0d expected 0 3", spawn_valid, spawn_piece); end
    spawn_req = 1'b1; tick(); spawn_req = 1'b0;
    checks++; if (spawn_piece !== 3'd5 || spawn_colour !== 12'hF00) begin errors++; $display("FAIL pop_second: got %0d %03h expected 5 F00", spawn_piece, spawn_colour); end
    tick();
    spawn_req = 1'b1; tick(); spawn_req = 1'b0;
    checks++; if (spawn_piece !== 3'd2 || spawn_colour !== 12'hFF0 || next_valid !== 1'b0 || next_piece !== 3'd0) begin errors++; $display("FAIL pop_third: got %0d %03h nv %0b np %0d expected 2 FF0 0 0", spawn_piece, spawn_colour, next_valid, next_piece); end
    tick();
  endtask

  task automatic test_empty_request();
    do_reset();
    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    checks++; if (req_pending !== 1'b1 || spawn_valid !== 1'b0) begin errors++; $display("FAIL empty_pending: got %0b %0b expected 1 0", req_pending, spawn_valid); end
    tick();
    tick();
    checks++; if (req_pending !== 1'b1 || spawn_valid !== 1'b0) begin errors++; $display("FAIL empty_wait: got %0b %0b expected 1 0", req_pending, spawn_valid); end
    rnd_in = 3'd6;
    tick();
    rnd_in = 3'd0;
    checks++; if (count !== 3'd1 || spawn_valid !== 1'b0) begin errors++; $display("FAIL empty_push: got count %0d valid %0b expected 1 0", count, spawn_valid); end
    tick();
    checks++; if (spawn_valid !== 1'b1 || spawn_piece !== 3'd6 || spawn_colour !== 12'h00F) begin errors++; $display("FAIL empty_serve: got %0b %0d %03h expected 1 6 00F", spawn_valid, spawn_piece, spawn_colour); end
    checks++; if (count !== 3'd0 || req_pending !== 1'b0) begin errors++; $display("FAIL empty_after: got count %0d pend %0b expected 0 0", count, req_pending); end
    tick();
    checks++; if (spawn_valid !== 1'b0 || spawn_piece !== 3'd6) begin errors++; $display("FAIL empty_single_pulse: got %0b %0d expected 0 6", spawn_valid, spawn_piece); end
  endtask

  task automatic test_push_pop_full();
    logic [2:0] rv     [4];
    logic [2:0] exp_pc [4];
    logic [2:0] exp_nx [4];
    rv     = '{3'd7, 3'd1, 3'd4, 3'd6};
    exp_pc = '{3'd3, 3'd5, 3'd2, 3'd7};
    exp_nx = '{3'd5, 3'd2, 3'd7, 3'd1};
    fill_352();
    for (int i = 0; i < 4; i++) begin
      spawn_req = 1'b1;
      rnd_in    = rv[i];
      tick();
      spawn_req = 1'b0;
      rnd_in    = 3'd0;
      checks++; if (spawn_valid !== 1'b1 || spawn_piece !== exp_pc[i]) begin errors++; $display("FAIL pushpop_piece[%0d]: got %0b %0d expected 1 %0d", i, spawn_valid, spawn_piece, exp_pc[i]); end
      checks++; if (count !== 3'd3 || next_piece !== exp_nx[i]) begin errors++; $display("FAIL pushpop_queue[%0d]: got count %0d next %0d expected 3 %0d", i, count, next_piece, exp_nx[i]); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    fill_352();
    spawn_req = 1'b1;
    tick();
    checks++; if (spawn_valid !== 1'b1 || spawn_piece !== 3'd3 || count !== 3'd2) begin errors++; $display("FAIL b2b_first: got %0b %0d count %0d expected 1 3 2", spawn_valid, spawn_piece, count); end
    tick();
    checks++; if (spawn_valid !== 1'b0 || count !== 3'd2 || next_piece !== 3'd5) begin errors++; $display("FAIL b2b_ignored: got %0b count %0d next %0d expected 0 2 5", spawn_valid, count, next_piece); end
    tick();
    spawn_req = 1'b0;
    checks++; if (spawn_valid !== 1'b1 || spawn_piece !== 3'd5 || count !== 3'd1) begin errors++; $display("FAIL b2b_third: got %0b %0d count %0d expected 1 5 1", spawn_valid, spawn_piece, count); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    rnd_in = 3'd3; tick(); rnd_in = 3'd0;
    spawn_req = 1'b1; tick(); spawn_req = 1'b0; tick();
    spawn_req = 1'b1; tick(); spawn_req = 1'b0;
    checks++; if (req_pending !== 1'b1 || dbg_state !== 1'b1) begin errors++; $display("FAIL mid_wait: got %0b %0b expected 1 1", req_pending, dbg_state); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (req_pending !== 1'b0 || spawn_valid !== 1'b0 || spawn_piece !== 3'd0 || spawn_colour !== 12'h000 || count !== 3'd0 || next_valid !== 1'b0) begin errors++; $display("FAIL mid_reset: got pend %0b v %0b p %0d c %03h n %0d nv %0b expected all 0", req_pending, spawn_valid, spawn_piece, spawn_colour, count, next_valid); end
    // Same value as before the reset: accepted only if last_accepted cleared.
    rnd_in = 3'd3;
    tick();
    rnd_in = 3'd0;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL mid_last_cleared: got %0d expected 1", count); end
    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    checks++; if (spawn_valid !== 1'b1 || spawn_piece !== 3'd3 || spawn_colour !== 12'hA0F || req_pending !== 1'b0) begin errors++; $display("FAIL mid_clean_serve: got %0b %0d %03h %0b expected 1 3 A0F 0", spawn_valid, spawn_piece, spawn_colour, req_pending); end
    tick();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    rnd_in    = 3'd0;
    spawn_req = 1'b0;
    test_reset();
    test_fill();
    test_reroll();
    test_pop_latency();
    test_empty_request();
    test_push_pop_full();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
